// File: rtl/pkg_display.sv
// Shared display definitions: blank segment code, hex-to-7-segment table
// and the scan state type.
package pkg_display;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } disp_state_t;

  // Active-low segments {g,f,e,d,c,b,a} for hex digits 0-F
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/module_hex_a_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module module_hex_a_7seg
  import pkg_display::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_c
);

  assign seg_c = hex7seg(nib_i);

endmodule

// File: rtl/module_lector_display.sv
// Time-multiplexed 7-segment scanner over NUM_DIGITS register nibbles, with a
// frame-aligned shadow copy so a mid-scan write never shows a torn frame.
module module_lector_display
  import pkg_display::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_CYCLES = 10000,
  parameter int unsigned GUARD_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       dp_data_i,
  input  logic                          dp_load_i,
  input  logic                          en_i,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [6:0]                    seg_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int unsigned IDX_W         = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W         = $clog2(REFRESH_CYCLES);
  localparam int unsigned DATA_W        = 4 * NUM_DIGITS;
  localparam int unsigned ACTIVE_CYCLES = REFRESH_CYCLES - GUARD_CYCLES;

  disp_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] staging_q, staging_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              frame_q, frame_d;

  logic [3:0]        nib_sel_c;
  logic [6:0]        seg_sel_c;
  logic              cnt_last_c;
  logic              idx_last_c;
  logic              scan_go_c;
  logic              boundary_c;

  assign nib_sel_c  = 4'(shadow_q >> {idx_q, 2'b00});
  assign cnt_last_c = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
  assign idx_last_c = (idx_q == IDX_W'(NUM_DIGITS - 1));

  module_hex_a_7seg u_hex (
    .nib_i (nib_sel_c),
    .seg_c (seg_sel_c)
  );

  // Next-state: scan sequencing, output decode and snapshot path
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    staging_d  = staging_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    an_d       = '1;
    seg_d      = seg_q;
    frame_d    = 1'b0;
    scan_go_c  = 1'b0;
    boundary_c = 1'b0;

    case (state_q)
      BLANK: begin
        if (en_i) begin
          state_d   = SCAN;
          scan_go_c = 1'b1;
        end
      end
      SCAN: begin
        if (!en_i) begin
          state_d = BLANK;
        end else begin
          scan_go_c = 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase

    // The enable cycle itself already runs slot 0, so each slot is a full period
    if (scan_go_c) begin
      boundary_c = cnt_last_c && idx_last_c;
      if (cnt_last_c) begin
        cnt_d = '0;
        idx_d = idx_last_c ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_q < CNT_W'(ACTIVE_CYCLES)) begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = seg_sel_c;
      end
      frame_d = boundary_c;
    end else begin
      cnt_d = '0;
      idx_d = '0;
      seg_d = SEG_BLANK;
    end

    // A load on the boundary cycle bypasses staging and lands in the new frame
    if (boundary_c) begin
      shadow_d  = dp_load_i ? dp_data_i : (pending_q ? staging_q : shadow_q);
      pending_d = 1'b0;
      if (dp_load_i) begin
        staging_d = dp_data_i;
      end
    end else begin
      if ((state_q == BLANK) && pending_q) begin
        shadow_d  = staging_q;
        pending_d = 1'b0;
      end
      if (dp_load_i) begin
        staging_d = dp_data_i;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign digit_idx_o = idx_q;
  assign frame_o     = frame_q;

endmodule
